// File: rtl/dmux_stream.sv
// Registered 1-to-N stream demux with a one-entry holding register and valid/ready on every side.
// Optional per-channel saturating delivery counters are enabled by defining DMUX_CNT_EN.

`ifdef DMUX_CNT_EN
module dmux_cnt_lane #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   output logic [CNT_W-1:0] cnt
);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt <= '0;
      else if (inc && !(&cnt))
         cnt <= cnt + 1'b1;
   end
endmodule
`endif

module dmux_stream #(
   parameter int N      = 4,
   parameter int DATA_W = 8,
   parameter int SEL_W  = 2,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [SEL_W-1:0]  in_sel,
   output logic [N-1:0]      out_valid,
   input  logic [N-1:0]      out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              sel_err
`ifdef DMUX_CNT_EN
   ,
   output logic [N*CNT_W-1:0] cnt_flat
`endif
);
   localparam int SEL_N = 1 << SEL_W;
   localparam int SW1   = SEL_W + 1;

   typedef enum logic {EMPTY, FULL} state_t;

   state_t             state, state_nxt;
   logic [SEL_W-1:0]   hold_sel;
   logic [SEL_N-1:0]   ready_pad;
   logic               full, accept, sel_ok, drain, load;

   // Pad out_ready to the full select range so hold_sel indexes it safely.
   assign ready_pad = SEL_N'(out_ready);
   assign full      = (state == FULL);
   assign drain     = full && ready_pad[hold_sel];
   assign in_ready  = !full || ready_pad[hold_sel];
   assign accept    = in_valid && in_ready;
   assign sel_ok    = {1'b0, in_sel} < SW1'(N);

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      if (accept && sel_ok) begin
         state_nxt = FULL;
         load      = 1'b1;
      end else if (drain) begin
         state_nxt = EMPTY;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= EMPTY;
         hold_sel <= '0;
         out_data <= '0;
         sel_err  <= 1'b0;
      end else begin
         state   <= state_nxt;
         sel_err <= accept && !sel_ok;
         if (load) begin
            hold_sel <= in_sel;
            out_data <= in_data;
         end
      end
   end

   for (genvar k = 0; k < N; k++) begin : g_lane
      assign out_valid[k] = full && (hold_sel == SEL_W'(k));
`ifdef DMUX_CNT_EN
      dmux_cnt_lane #(.CNT_W(CNT_W)) u_cnt (
         .clk   (clk),
         .rst_n (rst_n),
         .inc   (out_valid[k] && out_ready[k]),
         .cnt   (cnt_flat[k*CNT_W +: CNT_W])
      );
`endif
   end

endmodule

// File: tb/tb_dmux_stream.sv
// Directed bench for dmux_stream: N=4 instance for the main behaviour, N=3 instance for bad selects.
`timescale 1ns/1ps
module tb_dmux_stream;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;

   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] in_data = '0;
   logic [1:0] in_sel = '0;
   logic [3:0] out_valid;
   logic [3:0] out_ready = '0;
   logic [7:0] out_data;
   logic       sel_err;

   logic       b_valid = 1'b0;
   logic       b_in_ready;
   logic [7:0] b_data = '0;
   logic [1:0] b_sel = '0;
   logic [2:0] b_out_valid;
   logic [2:0] b_ready = '0;
   logic [7:0] b_out_data;
   logic       b_sel_err;
`ifdef DMUX_CNT_EN
   logic [7:0] cnt_flat;
   logic [5:0] b_cnt_flat;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   dmux_stream #(.N(4), .DATA_W(8), .SEL_W(2), .CNT_W(2)) u0 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_sel(in_sel), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .sel_err(sel_err)
`ifdef DMUX_CNT_EN
      , .cnt_flat(cnt_flat)
`endif
   );

   dmux_stream #(.N(3), .DATA_W(8), .SEL_W(2), .CNT_W(2)) u1 (
      .clk(clk), .rst_n(rst_n), .in_valid(b_valid), .in_ready(b_in_ready),
      .in_data(b_data), .in_sel(b_sel), .out_valid(b_out_valid),
      .out_ready(b_ready), .out_data(b_out_data), .sel_err(b_sel_err)
`ifdef DMUX_CNT_EN
      , .cnt_flat(b_cnt_flat)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

`ifdef DMUX_CNT_EN
   task automatic chk_cnt(input string tag, input logic [7:0] exp);
      for (int k = 0; k < 4; k++)
         chk($sformatf("%s_ch%0d", tag, k), 32'(cnt_flat[k*2 +: 2]), 32'(exp[k*2 +: 2]));
   endtask
`endif

   initial begin
      // Reset state
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'h0);
      chk("rst_out_data",  32'(out_data),  32'h0);
      chk("rst_in_ready",  32'(in_ready),  32'h1);
      chk("rst_sel_err",   32'(sel_err),   32'h0);
      chk("rst_b_sel_err", 32'(b_sel_err), 32'h0);
      tick();
      rst_n = 1'b1;
      tick();

      // Reset mid-word: async reset discards the held word immediately
      in_valid = 1'b1; in_sel = 2'd2; in_data = 8'hA5; out_ready = 4'b0000;
      tick();
      in_valid = 1'b0;
      chk("mid_hold_valid", 32'(out_valid), 32'h4);
      chk("mid_hold_ready", 32'(in_ready),  32'h0);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(out_valid), 32'h0);
      chk("mid_rst_data",  32'(out_data),  32'h0);
      chk("mid_rst_ready", 32'(in_ready),  32'h1);
`ifdef DMUX_CNT_EN
      chk_cnt("mid_rst_cnt", 8'h00);
`endif
      tick();
      rst_n = 1'b1;
      tick();
      chk("mid_after_valid", 32'(out_valid), 32'h0);

      // Single delivery
      out_ready = 4'b1111;
      in_valid = 1'b1; in_sel = 2'd1; in_data = 8'h3C;
      #1 chk("single_in_ready", 32'(in_ready), 32'h1);
      tick();
      in_valid = 1'b0;
      chk("single_valid", 32'(out_valid), 32'h2);
      chk("single_data",  32'(out_data),  32'h3C);
      tick();
      chk("single_drained", 32'(out_valid), 32'h0);
      chk("single_retain",  32'(out_data),  32'h3C);

      // Back-pressure on channel 3; other channels' ready must not matter
      out_ready = 4'b0111;
      in_valid = 1'b1; in_sel = 2'd3; in_data = 8'h5A;
      tick();
      in_sel = 2'd0; in_data = 8'h77;
      for (int i = 0; i < 5; i++) begin
         out_ready = {1'b0, 3'(i + 5)};
         #1;
         chk($sformatf("bp_valid_%0d", i), 32'(out_valid), 32'h8);
         chk($sformatf("bp_data_%0d", i),  32'(out_data),  32'h5A);
         chk($sformatf("bp_ready_%0d", i), 32'(in_ready),  32'h0);
         tick();
      end
      out_ready = 4'b1111;
      #1 chk("bp_release_ready", 32'(in_ready), 32'h1);
      tick();
      in_valid = 1'b0;
      chk("bp_next_valid", 32'(out_valid), 32'h1);
      chk("bp_next_data",  32'(out_data),  32'h77);
      tick();
      chk("bp_drained", 32'(out_valid), 32'h0);

      // Full throughput stream
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; in_sel = 2'(i); in_data = 8'h10 + 8'(i);
         #1 chk($sformatf("tp_ready_%0d", i), 32'(in_ready), 32'h1);
         tick();
         chk($sformatf("tp_valid_%0d", i), 32'(out_valid), 32'(4'b0001 << i));
         chk($sformatf("tp_data_%0d", i),  32'(out_data),  32'h10 + 32'(i));
      end
      in_valid = 1'b0;
      tick();
      chk("tp_drained", 32'(out_valid), 32'h0);
      chk("tp_sel_err", 32'(sel_err),   32'h0);
`ifdef DMUX_CNT_EN
      // ch0: 77,10  ch1: 3C,11  ch2: 12  ch3: 5A,13
      chk_cnt("mix_cnt", {2'd2, 2'd1, 2'd2, 2'd2});

      // Saturation: six transfers to channel 0 with CNT_W=2
      rst_n = 1'b0;
      #1 chk_cnt("clr_cnt", 8'h00);
      tick();
      rst_n = 1'b1;
      tick();
      in_valid = 1'b1; in_sel = 2'd0;
      for (int i = 0; i < 6; i++) begin
         in_data = 8'(i);
         tick();
      end
      in_valid = 1'b0;
      tick();
      chk_cnt("sat_cnt", {2'd0, 2'd0, 2'd0, 2'd3});
`endif

      // Bad select on N=3 instance
      b_ready = 3'b111;
      b_valid = 1'b1; b_sel = 2'd3; b_data = 8'hFF;
      #1 chk("bad_in_ready", 32'(b_in_ready), 32'h1);
      tick();
      b_valid = 1'b0;
      chk("bad_valid",    32'(b_out_valid), 32'h0);
      chk("bad_err",      32'(b_sel_err),   32'h1);
      chk("bad_empty",    32'(b_in_ready),  32'h1);
      tick();
      chk("bad_err_pulse", 32'(b_sel_err),  32'h0);
      chk("bad_valid2",    32'(b_out_valid), 32'h0);

      // Good select on N=3 instance
      b_valid = 1'b1; b_sel = 2'd2; b_data = 8'h42;
      tick();
      b_valid = 1'b0;
      chk("good3_valid", 32'(b_out_valid), 32'h4);
      chk("good3_data",  32'(b_out_data),  32'h42);
      chk("good3_err",   32'(b_sel_err),   32'h0);
      tick();

      // Bad select accepted while the held word drains: register empties
      b_ready = 3'b000;
      b_valid = 1'b1; b_sel = 2'd0; b_data = 8'h11;
      tick();
      chk("drainbad_hold", 32'(b_out_valid), 32'h1);
      b_ready = 3'b001; b_sel = 2'd3; b_data = 8'hEE;
      #1 chk("drainbad_ready", 32'(b_in_ready), 32'h1);
      tick();
      b_valid = 1'b0;
      chk("drainbad_valid", 32'(b_out_valid), 32'h0);
      chk("drainbad_err",   32'(b_sel_err),   32'h1);
      chk("drainbad_data",  32'(b_out_data),  32'h11);
      tick();
      chk("drainbad_err2",  32'(b_sel_err),   32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
